// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_pkg
//  Purpose  : Shared types and defaults for the unified memory-port arbiter.
//             Holds the arbiter state encoding, the requester identifiers and
//             the default address/data widths.
//  Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  localparam int unsigned DEF_AW = 32;
  localparam int unsigned DEF_DW = 32;

  // Arbiter states. IF_DROP is an in-flight fetch whose result is discarded
  // because the pipeline redirected while the bus was still busy.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IF_BUSY  = 2'd1,
    LSU_BUSY = 2'd2,
    IF_DROP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    REQ_IF  = 1'b0,
    REQ_LSU = 1'b1
  } req_id_e;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one memory port between instruction fetch (IF) and the
//             load/store unit (LSU). One transaction is outstanding at a
//             time; LSU has priority, limited by a streak counter so that a
//             waiting fetch is eventually served.
//  Ports    :
//    clk, rst_n          clock (rising edge), async active-low reset
//    i_if_req/addr/flush fetch request, address, pipeline redirect
//    o_if_rdata/valid    fetched word and its one-cycle valid pulse
//    i_lsu_*             load/store command (req, we, be, addr, wdata)
//    o_lsu_rdata/valid   load data and completion pulse
//    o_mem_*             registered memory command, held until ack
//    i_mem_rdata/ack     memory response
//    o_if_stall          i_if_req and no if_valid this cycle
//    o_lsu_stall         i_lsu_req and no lsu_valid this cycle
//  Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW         = DEF_AW,
  parameter int unsigned DW         = DEF_DW,
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_if_req,
  input  logic [AW-1:0]   i_if_addr,
  input  logic            i_if_flush,
  output logic [DW-1:0]   o_if_rdata,
  output logic            o_if_valid,
  input  logic            i_lsu_req,
  input  logic            i_lsu_we,
  input  logic [DW/8-1:0] i_lsu_be,
  input  logic [AW-1:0]   i_lsu_addr,
  input  logic [DW-1:0]   i_lsu_wdata,
  output logic [DW-1:0]   o_lsu_rdata,
  output logic            o_lsu_valid,
  output logic            o_mem_req,
  output logic            o_mem_we,
  output logic [DW/8-1:0] o_mem_be,
  output logic [AW-1:0]   o_mem_addr,
  output logic [DW-1:0]   o_mem_wdata,
  input  logic [DW-1:0]   i_mem_rdata,
  input  logic            i_mem_ack,
  output logic            o_if_stall,
  output logic            o_lsu_stall
);

  localparam int unsigned     c_SW           = $clog2(MAX_STREAK + 1);
  localparam logic [c_SW-1:0] c_STREAK_MAX   = c_SW'(MAX_STREAK);
  localparam logic [c_SW-1:0] c_STREAK_ONE   = c_SW'(1);

  arb_state_e      r_state;
  arb_state_e      w_state_nxt;
  logic [c_SW-1:0] r_streak;

  logic            r_mem_req;
  logic            r_mem_we;
  logic [DW/8-1:0] r_mem_be;
  logic [AW-1:0]   r_mem_addr;
  logic [DW-1:0]   r_mem_wdata;
  logic [DW-1:0]   r_if_rdata;
  logic            r_if_valid;
  logic [DW-1:0]   r_lsu_rdata;
  logic            r_lsu_valid;

  logic            w_ack;
  logic            w_if_elig;
  logic            w_lsu_elig;
  logic            w_lsu_wins;
  logic            w_if_wins;
  logic            w_grant_if;
  logic            w_grant_lsu;
  logic            w_if_done;
  logic            w_lsu_done;
  logic            w_txn_end;
  req_id_e         w_grant_id;

  // An ack only counts while a command is actually on the bus.
  assign w_ack = i_mem_ack & r_mem_req;

  // A requester completing this cycle still holds its req; mask it so the
  // same request is not issued twice. A redirect also cancels the fetch.
  assign w_if_elig  = i_if_req & ~r_if_valid & ~i_if_flush;
  assign w_lsu_elig = i_lsu_req & ~r_lsu_valid;

  assign w_lsu_wins = w_lsu_elig & (~w_if_elig | (r_streak < c_STREAK_MAX));
  assign w_if_wins  = w_if_elig & ~w_lsu_wins;
  assign w_grant_id = w_grant_lsu ? REQ_LSU : REQ_IF;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_lsu_wins) begin
          w_state_nxt = LSU_BUSY;
        end else if (w_if_wins) begin
          w_state_nxt = IF_BUSY;
        end
      end
      IF_BUSY: begin
        if (w_ack) begin
          w_state_nxt = IDLE;
        end else if (i_if_flush) begin
          w_state_nxt = IF_DROP;
        end
      end
      IF_DROP, LSU_BUSY: begin
        if (w_ack) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State-decoded actions
  // --------------------------------------------------------------------------
  always_comb begin
    w_grant_if  = 1'b0;
    w_grant_lsu = 1'b0;
    w_if_done   = 1'b0;
    w_lsu_done  = 1'b0;
    w_txn_end   = 1'b0;
    case (r_state)
      IDLE: begin
        w_grant_lsu = w_lsu_wins;
        w_grant_if  = w_if_wins;
      end
      IF_BUSY: begin
        w_txn_end = w_ack;
        // A redirect landing together with the ack discards the data.
        w_if_done = w_ack & ~i_if_flush;
      end
      IF_DROP: begin
        w_txn_end = w_ack;
      end
      LSU_BUSY: begin
        w_txn_end  = w_ack;
        w_lsu_done = w_ack;
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Memory command, response data and completion pulses
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_if_valid  <= 1'b0;
      r_lsu_rdata <= '0;
      r_lsu_valid <= 1'b0;
    end else begin
      r_if_valid  <= w_if_done;
      r_lsu_valid <= w_lsu_done;
      if (w_if_done) begin
        r_if_rdata <= i_mem_rdata;
      end
      // Stores leave the last load result untouched.
      if (w_lsu_done && !r_mem_we) begin
        r_lsu_rdata <= i_mem_rdata;
      end
      if (w_grant_if || w_grant_lsu) begin
        r_mem_req <= 1'b1;
        case (w_grant_id)
          REQ_LSU: begin
            r_mem_we    <= i_lsu_we;
            r_mem_be    <= i_lsu_be;
            r_mem_addr  <= i_lsu_addr;
            r_mem_wdata <= i_lsu_wdata;
          end
          default: begin
            r_mem_we    <= 1'b0;
            r_mem_be    <= '1;
            r_mem_addr  <= i_if_addr;
            r_mem_wdata <= '0;
          end
        endcase
      end else if (w_txn_end) begin
        r_mem_req <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Anti-starvation streak: LSU grants taken while a live fetch waits.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_streak <= '0;
    end else if (r_state == IDLE) begin
      if (!i_if_req || w_grant_if) begin
        r_streak <= '0;
      end else if (w_grant_lsu && !i_if_flush && (r_streak != c_STREAK_MAX)) begin
        r_streak <= r_streak + c_STREAK_ONE;
      end
    end
  end

  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_be    = r_mem_be;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_if_rdata  = r_if_rdata;
  assign o_if_valid  = r_if_valid;
  assign o_lsu_rdata = r_lsu_rdata;
  assign o_lsu_valid = r_lsu_valid;
  assign o_if_stall  = i_if_req & ~r_if_valid;
  assign o_lsu_stall = i_lsu_req & ~r_lsu_valid;

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Self-checking bench for mem_port_arbiter: a per-cycle vector
//             table, directed multi-cycle sequences (flush, streak limit,
//             reset mid-transaction) and randomized traffic against a
//             transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int c_MAX_STREAK = 4;
  localparam int c_NV         = 17;
  localparam int c_OWN_NONE   = 0;
  localparam int c_OWN_IF     = 1;
  localparam int c_OWN_LSU    = 2;

  logic        clk;
  logic        rst_n;
  logic        if_req, if_flush, if_valid, if_stall;
  logic [31:0] if_addr, if_rdata;
  logic        lsu_req, lsu_we, lsu_valid, lsu_stall;
  logic [3:0]  lsu_be;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  mem_port_arbiter #(.AW(32), .DW(32), .MAX_STREAK(c_MAX_STREAK)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_if_req   (if_req),
    .i_if_addr  (if_addr),
    .i_if_flush (if_flush),
    .o_if_rdata (if_rdata),
    .o_if_valid (if_valid),
    .i_lsu_req  (lsu_req),
    .i_lsu_we   (lsu_we),
    .i_lsu_be   (lsu_be),
    .i_lsu_addr (lsu_addr),
    .i_lsu_wdata(lsu_wdata),
    .o_lsu_rdata(lsu_rdata),
    .o_lsu_valid(lsu_valid),
    .o_mem_req  (mem_req),
    .o_mem_we   (mem_we),
    .o_mem_be   (mem_be),
    .o_mem_addr (mem_addr),
    .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata),
    .i_mem_ack  (mem_ack),
    .o_if_stall (if_stall),
    .o_lsu_stall(lsu_stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 40) $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_flush = 1'b0; if_addr = '0;
    lsu_req = 1'b0; lsu_we = 1'b0; lsu_be = '0; lsu_addr = '0; lsu_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
  endtask

  // --------------------------------------------------------------------------
  // Vector table: inputs of one cycle and the outputs expected in that cycle.
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic        if_req;
    logic        if_flush;
    logic [31:0] if_addr;
    logic        lsu_req;
    logic        lsu_we;
    logic [3:0]  lsu_be;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        e_mem_req;
    logic        e_mem_we;
    logic [31:0] e_mem_addr;
    logic [3:0]  e_mem_be;
    logic [31:0] e_mem_wdata;
    logic        e_if_valid;
    logic [31:0] e_if_rdata;
    logic        e_lsu_valid;
    logic [31:0] e_lsu_rdata;
    logic        e_if_stall;
    logic        e_lsu_stall;
  } vec_t;

  vec_t tbl [c_NV];

  // Reference model state (transaction level).
  int          m_owner, n_owner;
  bit          m_drop, n_drop;
  bit          m_mem_req, n_mem_req, m_we, n_we;
  logic [3:0]  m_be, n_be;
  logic [31:0] m_addr, n_addr, m_wdata, n_wdata;
  logic [31:0] m_if_rdata, n_if_rdata, m_lsu_rdata, n_lsu_rdata;
  bit          m_if_valid, n_if_valid, m_lsu_valid, n_lsu_valid;
  int          m_streak, n_streak;
  bit          ie, le, ack_eff;
  int          win;

  bit          if_act, l_act;
  logic [31:0] if_a;
  int          wait_left;

  task automatic model_reset();
    m_owner = c_OWN_NONE; m_drop = 0; m_mem_req = 0; m_we = 0; m_be = '0;
    m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_lsu_rdata = '0;
    m_if_valid = 0; m_lsu_valid = 0; m_streak = 0;
  endtask

  task automatic model_next();
    n_owner = m_owner; n_drop = m_drop; n_mem_req = m_mem_req; n_we = m_we;
    n_be = m_be; n_addr = m_addr; n_wdata = m_wdata; n_if_rdata = m_if_rdata;
    n_lsu_rdata = m_lsu_rdata; n_if_valid = 0; n_lsu_valid = 0; n_streak = m_streak;
    ack_eff = mem_ack && m_mem_req;
    if (m_owner == c_OWN_NONE) begin
      ie = if_req && !m_if_valid && !if_flush;
      le = lsu_req && !m_lsu_valid;
      win = c_OWN_NONE;
      if (ie && le) win = (m_streak < c_MAX_STREAK) ? c_OWN_LSU : c_OWN_IF;
      else if (le)  win = c_OWN_LSU;
      else if (ie)  win = c_OWN_IF;
      if (!if_req || win == c_OWN_IF) n_streak = 0;
      else if (win == c_OWN_LSU && !if_flush && m_streak < c_MAX_STREAK) n_streak = m_streak + 1;
      if (win == c_OWN_IF) begin
        n_owner = c_OWN_IF; n_drop = 0; n_mem_req = 1; n_we = 0; n_addr = if_addr;
      end else if (win == c_OWN_LSU) begin
        n_owner = c_OWN_LSU; n_drop = 0; n_mem_req = 1; n_we = lsu_we;
        n_be = lsu_be; n_addr = lsu_addr; n_wdata = lsu_wdata;
      end
    end else begin
      if (m_owner == c_OWN_IF && !ack_eff && if_flush) n_drop = 1;
      if (ack_eff) begin
        n_mem_req = 0;
        n_owner = c_OWN_NONE;
        if (m_owner == c_OWN_IF && !m_drop && !if_flush) begin
          n_if_valid = 1; n_if_rdata = mem_rdata;
        end
        if (m_owner == c_OWN_LSU) begin
          n_lsu_valid = 1;
          if (!m_we) n_lsu_rdata = mem_rdata;
        end
      end
    end
  endtask

  task automatic model_commit();
    m_owner = n_owner; m_drop = n_drop; m_mem_req = n_mem_req; m_we = n_we;
    m_be = n_be; m_addr = n_addr; m_wdata = n_wdata; m_if_rdata = n_if_rdata;
    m_lsu_rdata = n_lsu_rdata; m_if_valid = n_if_valid; m_lsu_valid = n_lsu_valid;
    m_streak = n_streak;
  endtask

  initial begin
    // {if_req,flush,if_addr, lsu_req,we,be,addr,wdata, ack,rdata,
    //  e_mem_req,we,addr,be,wdata, e_if_valid,rdata, e_lsu_valid,rdata, e_if_stall,e_lsu_stall}
    // single fetch, zero-wait
    tbl[0]  = '{1'b1,1'b0,32'h10, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,32'h0,  1'b0,1'b0,32'h0,4'h0,32'h0, 1'b0,32'h0,  1'b0,32'h0, 1'b1,1'b0};
    tbl[1]  = '{1'b1,1'b0,32'h10, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b1,32'h13, 1'b1,1'b0,32'h10,4'h0,32'h0, 1'b0,32'h0,  1'b0,32'h0, 1'b1,1'b0};
    tbl[2]  = '{1'b1,1'b0,32'h10, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,32'h0,  1'b0,1'b0,32'h0,4'h0,32'h0,  1'b1,32'h13, 1'b0,32'h0, 1'b0,1'b0};
    tbl[3]  = '{1'b0,1'b0,32'h0,  1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,32'h0,  1'b0,1'b0,32'h0,4'h0,32'h0,  1'b0,32'h13, 1'b0,32'h0, 1'b0,1'b0};
    // simultaneous fetch + load: LSU first, IF granted in the lsu_valid cycle
    tbl[4]  = '{1'b1,1'b0,32'h20, 1'b1,1'b0,4'hF,32'h100,32'h0, 1'b0,32'h0, 1'b0,1'b0,32'h0,4'h0,32'h0, 1'b0,32'h13, 1'b0,32'h0, 1'b1,1'b1};
    tbl[5]  = '{1'b1,1'b0,32'h20, 1'b1,1'b0,4'hF,32'h100,32'h0, 1'b1,32'hCAFE0001, 1'b1,1'b0,32'h100,4'h0,32'h0, 1'b0,32'h13, 1'b0,32'h0, 1'b1,1'b1};
    tbl[6]  = '{1'b1,1'b0,32'h20, 1'b1,1'b0,4'hF,32'h100,32'h0, 1'b0,32'h0, 1'b0,1'b0,32'h0,4'h0,32'h0, 1'b0,32'h13, 1'b1,32'hCAFE0001, 1'b1,1'b0};
    tbl[7]  = '{1'b1,1'b0,32'h20, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,32'h0, 1'b1,1'b0,32'h20,4'h0,32'h0, 1'b0,32'h13, 1'b0,32'hCAFE0001, 1'b1,1'b0};
    tbl[8]  = '{1'b1,1'b0,32'h20, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b1,32'h93, 1'b1,1'b0,32'h20,4'h0,32'h0, 1'b0,32'h13, 1'b0,32'hCAFE0001, 1'b1,1'b0};
    tbl[9]  = '{1'b1,1'b0,32'h20, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,32'h0, 1'b0,1'b0,32'h0,4'h0,32'h0, 1'b1,32'h93, 1'b0,32'hCAFE0001, 1'b0,1'b0};
    tbl[10] = '{1'b0,1'b0,32'h0,  1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,32'h0, 1'b0,1'b0,32'h0,4'h0,32'h0, 1'b0,32'h93, 1'b0,32'hCAFE0001, 1'b0,1'b0};
    // store with 3-cycle ack delay
    tbl[11] = '{1'b0,1'b0,32'h0, 1'b1,1'b1,4'h3,32'h200,32'hDEADBEEF, 1'b0,32'h0, 1'b0,1'b0,32'h0,4'h0,32'h0, 1'b0,32'h93, 1'b0,32'hCAFE0001, 1'b0,1'b1};
    tbl[12] = '{1'b0,1'b0,32'h0, 1'b1,1'b1,4'h3,32'h200,32'hDEADBEEF, 1'b0,32'h0, 1'b1,1'b1,32'h200,4'h3,32'hDEADBEEF, 1'b0,32'h93, 1'b0,32'hCAFE0001, 1'b0,1'b1};
    tbl[13] = '{1'b0,1'b0,32'h0, 1'b1,1'b1,4'h3,32'h200,32'hDEADBEEF, 1'b0,32'h0, 1'b1,1'b1,32'h200,4'h3,32'hDEADBEEF, 1'b0,32'h93, 1'b0,32'hCAFE0001, 1'b0,1'b1};
    tbl[14] = '{1'b0,1'b0,32'h0, 1'b1,1'b1,4'h3,32'h200,32'hDEADBEEF, 1'b1,32'h12345678, 1'b1,1'b1,32'h200,4'h3,32'hDEADBEEF, 1'b0,32'h93, 1'b0,32'hCAFE0001, 1'b0,1'b1};
    tbl[15] = '{1'b0,1'b0,32'h0, 1'b1,1'b1,4'h3,32'h200,32'hDEADBEEF, 1'b0,32'h0, 1'b0,1'b0,32'h0,4'h0,32'h0, 1'b0,32'h93, 1'b1,32'hCAFE0001, 1'b0,1'b0};
    tbl[16] = '{1'b0,1'b0,32'h0, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,32'h0, 1'b0,1'b0,32'h0,4'h0,32'h0, 1'b0,32'h93, 1'b0,32'hCAFE0001, 1'b0,1'b0};

    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset mem_req", {31'd0, mem_req}, 32'd0);
    chk("reset if_valid", {31'd0, if_valid}, 32'd0);
    chk("reset lsu_valid", {31'd0, lsu_valid}, 32'd0);
    chk("reset if_rdata", if_rdata, 32'd0);
    chk("reset lsu_rdata", lsu_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < c_NV; i++) begin
      @(negedge clk);
      if_req = tbl[i].if_req; if_flush = tbl[i].if_flush; if_addr = tbl[i].if_addr;
      lsu_req = tbl[i].lsu_req; lsu_we = tbl[i].lsu_we; lsu_be = tbl[i].lsu_be;
      lsu_addr = tbl[i].lsu_addr; lsu_wdata = tbl[i].lsu_wdata;
      mem_ack = tbl[i].mem_ack; mem_rdata = tbl[i].mem_rdata;
      #1;
      chk($sformatf("t%0d mem_req", i), {31'd0, mem_req}, {31'd0, tbl[i].e_mem_req});
      if (tbl[i].e_mem_req) begin
        chk($sformatf("t%0d mem_we", i), {31'd0, mem_we}, {31'd0, tbl[i].e_mem_we});
        chk($sformatf("t%0d mem_addr", i), mem_addr, tbl[i].e_mem_addr);
        if (tbl[i].e_mem_we) begin
          chk($sformatf("t%0d mem_be", i), {28'd0, mem_be}, {28'd0, tbl[i].e_mem_be});
          chk($sformatf("t%0d mem_wdata", i), mem_wdata, tbl[i].e_mem_wdata);
        end
      end
      chk($sformatf("t%0d if_valid", i), {31'd0, if_valid}, {31'd0, tbl[i].e_if_valid});
      chk($sformatf("t%0d if_rdata", i), if_rdata, tbl[i].e_if_rdata);
      chk($sformatf("t%0d lsu_valid", i), {31'd0, lsu_valid}, {31'd0, tbl[i].e_lsu_valid});
      chk($sformatf("t%0d lsu_rdata", i), lsu_rdata, tbl[i].e_lsu_rdata);
      chk($sformatf("t%0d if_stall", i), {31'd0, if_stall}, {31'd0, tbl[i].e_if_stall});
      chk($sformatf("t%0d lsu_stall", i), {31'd0, lsu_stall}, {31'd0, tbl[i].e_lsu_stall});
    end

    // ---------------- flush during fetch, 3-cycle ack ----------------
    @(negedge clk); idle_inputs(); if_req = 1'b1; if_addr = 32'h40; #1;
    chk("fl c0 mem_req", {31'd0, mem_req}, 32'd0);
    @(negedge clk); if_flush = 1'b1; #1;
    chk("fl c1 mem_req", {31'd0, mem_req}, 32'd1);
    chk("fl c1 mem_addr", mem_addr, 32'h40);
    @(negedge clk); if_flush = 1'b0; if_addr = 32'h80; #1;
    chk("fl c2 mem_req held", {31'd0, mem_req}, 32'd1);
    chk("fl c2 mem_addr", mem_addr, 32'h40);
    @(negedge clk); mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0; #1;
    chk("fl c3 mem_req held", {31'd0, mem_req}, 32'd1);
    @(negedge clk); mem_ack = 1'b0; #1;
    chk("fl c4 mem_req", {31'd0, mem_req}, 32'd0);
    chk("fl c4 if_valid", {31'd0, if_valid}, 32'd0);
    chk("fl c4 if_rdata kept", if_rdata, 32'h93);
    @(negedge clk); mem_ack = 1'b1; mem_rdata = 32'h55; #1;
    chk("fl c5 mem_req", {31'd0, mem_req}, 32'd1);
    chk("fl c5 mem_addr new", mem_addr, 32'h80);
    @(negedge clk); mem_ack = 1'b0; #1;
    chk("fl c6 if_valid", {31'd0, if_valid}, 32'd1);
    chk("fl c6 if_rdata", if_rdata, 32'h55);
    @(negedge clk); idle_inputs(); #1;
    chk("fl c7 if_valid", {31'd0, if_valid}, 32'd0);

    // ---------------- streak limit: 4 LSU grants, then IF ----------------
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      idle_inputs(); if_req = 1'b1; if_addr = 32'h400;
      lsu_req = 1'b1; lsu_be = 4'hF; lsu_addr = 32'h300 + 32'(k * 4); #1;
      chk($sformatf("st%0d idle mem_req", k), {31'd0, mem_req}, 32'd0);
      @(negedge clk); mem_ack = 1'b1; mem_rdata = 32'(k); #1;
      chk($sformatf("st%0d mem_req", k), {31'd0, mem_req}, 32'd1);
      chk($sformatf("st%0d winner addr", k), mem_addr, (k < 4) ? 32'h300 + 32'(k * 4) : 32'h400);
      @(negedge clk); mem_ack = 1'b0;
      if (k < 4) if_flush = 1'b1;
      else lsu_req = 1'b0;
      #1;
      chk($sformatf("st%0d lsu_valid", k), {31'd0, lsu_valid}, (k < 4) ? 32'd1 : 32'd0);
      chk($sformatf("st%0d if_valid", k), {31'd0, if_valid}, (k < 4) ? 32'd0 : 32'd1);
    end
    @(negedge clk); idle_inputs(); if_req = 1'b1; if_addr = 32'h404;
    lsu_req = 1'b1; lsu_be = 4'hF; lsu_addr = 32'h380; #1;
    chk("st clr idle", {31'd0, mem_req}, 32'd0);
    @(negedge clk); mem_ack = 1'b1; #1;
    chk("st clr lsu wins", mem_addr, 32'h380);
    @(negedge clk); idle_inputs(); #1;
    chk("st clr lsu_valid", {31'd0, lsu_valid}, 32'd1);

    // ---------------- reset during LSU transaction ----------------
    @(negedge clk); idle_inputs(); lsu_req = 1'b1; lsu_be = 4'hF; lsu_addr = 32'h500; #1;
    chk("rs c0 mem_req", {31'd0, mem_req}, 32'd0);
    @(negedge clk); #1;
    chk("rs c1 mem_req", {31'd0, mem_req}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rs async mem_req drop", {31'd0, mem_req}, 32'd0);
    @(negedge clk); lsu_req = 1'b0;
    @(negedge clk); rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hFFFF0000; #1;
    chk("rs late ack mem_req", {31'd0, mem_req}, 32'd0);
    @(negedge clk); mem_ack = 1'b0; #1;
    chk("rs no lsu_valid", {31'd0, lsu_valid}, 32'd0);
    chk("rs no if_valid", {31'd0, if_valid}, 32'd0);
    chk("rs lsu_rdata", lsu_rdata, 32'd0);
    @(negedge clk); if_req = 1'b1; if_addr = 32'h600; #1;
    chk("rs idle mem_req", {31'd0, mem_req}, 32'd0);
    @(negedge clk); mem_ack = 1'b1; mem_rdata = 32'h77; #1;
    chk("rs grant mem_req", {31'd0, mem_req}, 32'd1);
    chk("rs grant addr", mem_addr, 32'h600);
    @(negedge clk); mem_ack = 1'b0; #1;
    chk("rs if_valid", {31'd0, if_valid}, 32'd1);
    chk("rs if_rdata", if_rdata, 32'h77);

    // ---------------- randomized traffic vs. reference model ----------------
    @(negedge clk); idle_inputs(); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    if_act = 0; l_act = 0; if_a = '0; wait_left = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (m_if_valid) begin
        if_act = ($urandom_range(0, 1) == 1); if_a = $urandom & 32'hFFFF_FFFC;
      end else if (!if_act && $urandom_range(0, 2) == 0) begin
        if_act = 1; if_a = $urandom & 32'hFFFF_FFFC;
      end
      if_flush = ($urandom_range(0, 11) == 0);
      if (if_flush) begin
        if_act = ($urandom_range(0, 3) != 0); if_a = $urandom & 32'hFFFF_FFFC;
      end
      if (m_lsu_valid || (!l_act && $urandom_range(0, 2) == 0)) begin
        l_act = m_lsu_valid ? ($urandom_range(0, 1) == 1) : 1'b1;
        lsu_we = $urandom_range(0, 1) == 1;
        lsu_be = 4'($urandom_range(1, 15));
        lsu_addr = $urandom; lsu_wdata = $urandom;
      end
      if_req = if_act; if_addr = if_a; lsu_req = l_act;
      mem_ack = m_mem_req ? (wait_left == 0) : ($urandom_range(0, 7) == 0);
      mem_rdata = $urandom;
      #1;
      chk("rnd mem_req", {31'd0, mem_req}, {31'd0, m_mem_req});
      if (m_mem_req) begin
        chk("rnd mem_addr", mem_addr, m_addr);
        chk("rnd mem_we", {31'd0, mem_we}, {31'd0, m_we});
        if (m_we) begin
          chk("rnd mem_be", {28'd0, mem_be}, {28'd0, m_be});
          chk("rnd mem_wdata", mem_wdata, m_wdata);
        end
      end
      chk("rnd if_valid", {31'd0, if_valid}, {31'd0, m_if_valid});
      chk("rnd if_rdata", if_rdata, m_if_rdata);
      chk("rnd lsu_valid", {31'd0, lsu_valid}, {31'd0, m_lsu_valid});
      chk("rnd lsu_rdata", lsu_rdata, m_lsu_rdata);
      chk("rnd if_stall", {31'd0, if_stall}, {31'd0, if_req && !m_if_valid});
      chk("rnd lsu_stall", {31'd0, lsu_stall}, {31'd0, lsu_req && !m_lsu_valid});
      model_next();
      if (m_mem_req && !mem_ack) wait_left--;
      @(posedge clk);
      if (n_mem_req && !m_mem_req) wait_left = $urandom_range(0, 3);
      model_commit();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_mem_port_arbiter
`default_nettype wire
